// File: rtl/cpu6502_int_ctrl_pkg.sv
// Shared encodings for the 6502 interrupt controller: FSM states, cause codes
// and the vector low-byte constants driven onto the ADL vector mux.
package cpu6502_int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SVC  = 2'd2
    } int_state_e;

    typedef enum logic [1:0] {
        CAUSE_IRQ   = 2'd0,
        CAUSE_BRK   = 2'd1,
        CAUSE_NMI   = 2'd2,
        CAUSE_RESET = 2'd3
    } int_cause_e;

    localparam logic [7:0] VEC_NMI_LO   = 8'hFA;
    localparam logic [7:0] VEC_RESET_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO   = 8'hFE;

endpackage

// File: rtl/cpu6502_int_ctrl_sync_ff.sv
// Multi-flop synchronizer for one asynchronous level input; all flops clear
// on reset so the first post-reset edge is seen against a stored 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu6502_int_ctrl.sv
// 6502 interrupt/reset sequencing: NMI edge latch, IRQ masking, BRK/IRQ/NMI
// arbitration with NMI hijack, and vector/B-bit selection for the core.
//
// state | meaning
// RST   | reset sequence running, waiting for the reset vector fetch
// IDLE  | normal execution, watching for interrupts at instruction boundaries
// SVC   | BRK/IRQ/NMI sequence running, waiting for the vector fetch
module cpu6502_int_ctrl
    import cpu6502_int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2  // legal 2..3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nmi,
    input  logic       irq,
    input  logic       sync,
    input  logic       i_flag,
    input  logic       brk_start,
    input  logic       vec_fetch,
    output logic       int_take,
    output logic [7:0] vector_lo,
    output logic       push_b,
    output logic       in_service,
    output logic       reset_f,
    output logic [1:0] cause
);

    logic       nmi_s;
    logic       irq_s;
    logic       nmi_prev_q;
    logic       nmi_edge;
    logic       nmi_pend_q;
    logic       nmi_pend_d;
    logic       nmi_clr;
    logic       irq_act;
    logic       hijack;
    logic       push_b_q;
    int_state_e state_q;
    int_cause_e cause_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk   (clk),
        .reset (reset),
        .d_i   (nmi),
        .q_o   (nmi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_irq (
        .clk   (clk),
        .reset (reset),
        .d_i   (irq),
        .q_o   (irq_s)
    );

    assign nmi_edge = nmi_s & ~nmi_prev_q;
    assign irq_act  = irq_s & ~i_flag;
    assign int_take = (state_q == ST_IDLE) & sync & (nmi_pend_q | irq_act);

    // A fresh edge in the vector-fetch cycle re-arms the latch (set beats clear).
    assign nmi_clr    = (state_q == ST_SVC) & vec_fetch & (cause_q == CAUSE_NMI);
    assign nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);

    assign hijack = ((cause_q == CAUSE_IRQ) | (cause_q == CAUSE_BRK)) &
                    (nmi_edge | nmi_pend_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RST;
            cause_q    <= CAUSE_RESET;
            push_b_q   <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_s;
            nmi_pend_q <= nmi_pend_d;
            case (state_q)
                ST_RST: begin
                    if (vec_fetch) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (int_take) begin
                        state_q  <= ST_SVC;
                        cause_q  <= nmi_pend_q ? CAUSE_NMI : CAUSE_IRQ;
                        push_b_q <= 1'b0;
                    end else if (brk_start) begin
                        state_q  <= ST_SVC;
                        cause_q  <= CAUSE_BRK;
                        push_b_q <= 1'b1;
                    end
                end
                ST_SVC: begin
                    if (vec_fetch) begin
                        state_q <= ST_IDLE;
                    end else if (hijack) begin
                        cause_q <= CAUSE_NMI;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    always_comb begin
        vector_lo  = VEC_RESET_LO;
        push_b     = 1'b0;
        in_service = 1'b1;
        reset_f    = 1'b0;
        case (state_q)
            ST_RST: begin
                reset_f = 1'b1;
            end
            ST_IDLE: begin
                vector_lo  = VEC_IRQ_LO;
                push_b     = 1'b1;
                in_service = 1'b0;
            end
            ST_SVC: begin
                vector_lo = (cause_q == CAUSE_NMI) ? VEC_NMI_LO : VEC_IRQ_LO;
                push_b    = push_b_q;
            end
            default: begin
                reset_f = 1'b1;
            end
        endcase
    end

    assign cause = cause_q;

endmodule
